// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multicycle memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam int CNT_W = 4;

   function automatic logic [63:0] byte2word(input logic [63:0] byte_addr, input int lg_bytes);
      return byte_addr >> lg_bytes;
   endfunction

endpackage

// File: rtl/multicycle_mem_ctrl_ram.sv
// Single-port RAM with byte-enabled synchronous write and registered read.
module sp_byte_ram #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_WORDS = 64,
  parameter string MEM_INIT    = "",
  localparam int   NB          = DATA_W / 8,
  localparam int   AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Array has no reset: contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)         rdata_q <= '0;
    else if (en && !we) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/multicycle_mem_ctrl.sv
// Request/ready memory controller with wait states, byte enables and error reporting.
// Optional MMIO output register enabled by defining MEM_CTRL_MMIO_EN.
module multicycle_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                DEPTH_WORDS = 64,
   parameter int                WAIT_STATES = 2,
   parameter string             MEM_INIT    = "",
   parameter logic [ADDR_W-1:0] MMIO_ADDR   = 32'h0000_0100
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic                err,
   output logic [DATA_W-1:0]   WriteData,
   output logic [ADDR_W-1:0]   DataAdr,
   output logic                MemWrite,
   output logic [DATA_W-1:0]   mmio_out
);

   localparam int NB  = DATA_W / 8;
   localparam int BLG = (NB > 1) ? $clog2(NB) : 0;
   localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
`ifdef MEM_CTRL_MMIO_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               we_q, bad_q, hit_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [NB-1:0]      be_q;
   logic [AW-1:0]      widx_q;
   logic               ready_q, err_q, mw_q;
   logic [DATA_W-1:0]  wd_out_q;
   logic [ADDR_W-1:0]  adr_out_q;

   logic [63:0]        widx_d;
   logic               hit_d, bad_d, ram_en;
   logic [DATA_W-1:0]  ram_rdata;

   // Error classification happens at acceptance, from the live core inputs.
   always_comb begin
      widx_d = byte2word(64'(addr), BLG);
      hit_d  = MMIO_EN && (addr == MMIO_ADDR);
      bad_d  = ((addr & ADDR_W'(NB - 1)) != '0) || ((widx_d >= 64'(DEPTH_WORDS)) && !hit_d);
   end

   assign ram_en = reset && (state_q == RESP) && !bad_q && !hit_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         bad_q     <= 1'b0;
         hit_q     <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         mw_q      <= 1'b0;
         wd_out_q  <= '0;
         adr_out_q <= '0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         mw_q    <= 1'b0;
         case (state_q)
            IDLE: if (req) begin
               we_q    <= we;
               addr_q  <= addr;
               wdata_q <= wdata;
               be_q    <= be;
               widx_q  <= widx_d[AW-1:0];
               bad_q   <= bad_d;
               hit_q   <= hit_d;
               cnt_q   <= CNT_LOAD;
               state_q <= (WAIT_STATES > 0) ? ACCESS : RESP;
            end
            ACCESS: begin
               if (cnt_q == '0) state_q <= RESP;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            RESP: begin
               ready_q <= 1'b1;
               err_q   <= bad_q;
               if (!bad_q && we_q) begin
                  mw_q      <= 1'b1;
                  adr_out_q <= addr_q;
                  wd_out_q  <= wdata_q;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   sp_byte_ram #(
      .DATA_W      (DATA_W),
      .DEPTH_WORDS (DEPTH_WORDS),
      .MEM_INIT    (MEM_INIT)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .en    (ram_en),
      .we    (we_q),
      .be    (be_q),
      .addr  (widx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

`ifdef MEM_CTRL_MMIO_EN
   logic [DATA_W-1:0] mmio_q, mmio_rd_q;
   logic              rsel_q;

   // rsel_q remembers whether the last good read came from MMIO or the array.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mmio_q    <= '0;
         mmio_rd_q <= '0;
         rsel_q    <= 1'b0;
      end else if (state_q == RESP && !bad_q) begin
         if (hit_q && we_q) begin
            for (int i = 0; i < NB; i++) begin
               if (be_q[i]) mmio_q[i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
         end
         if (!we_q) begin
            rsel_q <= hit_q;
            if (hit_q) mmio_rd_q <= mmio_q;
         end
      end
   end

   assign rdata    = rsel_q ? mmio_rd_q : ram_rdata;
   assign mmio_out = mmio_q;
`else
   assign rdata    = ram_rdata;
   assign mmio_out = '0;
`endif

   assign ready     = ready_q;
   assign err       = err_q;
   assign MemWrite  = mw_q;
   assign WriteData = wd_out_q;
   assign DataAdr   = adr_out_q;

endmodule

// File: tb/tb_multicycle_mem_ctrl.sv
// Directed bench: instance 0 uses WAIT_STATES=2, instance 1 uses WAIT_STATES=0.
module tb_multicycle_mem_ctrl;

   localparam int WS_A = 2;
   localparam int WS_B = 0;

   logic        clk = 1'b0;
   logic        rst_s     [2];
   logic        req_s     [2];
   logic        we_s      [2];
   logic [31:0] addr_s    [2];
   logic [31:0] wdata_s   [2];
   logic [3:0]  be_s      [2];
   logic [31:0] rdata_s   [2];
   logic        ready_s   [2];
   logic        err_s     [2];
   logic [31:0] wdo_s     [2];
   logic [31:0] adr_s     [2];
   logic        mw_s      [2];
   logic [31:0] mmio_s    [2];

   int          n_chk = 0;
   int          n_err = 0;
   int          lat, gap;
   logic [31:0] rd, da, wdo;
   logic        e, mw, mw_any, any_evt;

   always #5 clk = ~clk;

   multicycle_mem_ctrl #(.WAIT_STATES(WS_A)) u_dut_a (
      .clk(clk), .reset(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .be(be_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]),
      .WriteData(wdo_s[0]), .DataAdr(adr_s[0]), .MemWrite(mw_s[0]), .mmio_out(mmio_s[0])
   );

   multicycle_mem_ctrl #(.WAIT_STATES(WS_B)) u_dut_b (
      .clk(clk), .reset(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .be(be_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]),
      .WriteData(wdo_s[1]), .DataAdr(adr_s[1]), .MemWrite(mw_s[1]), .mmio_out(mmio_s[1])
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One complete access; latency counts rising edges after the accepting edge.
   task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, input string tag);
      @(negedge clk);
      req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd; be_s[d] = b;
      @(posedge clk); #1;
      req_s[d] = 1'b0;
      lat = 0;
      mw_any = mw_s[d];
      while (!ready_s[d] && lat < 30) begin
         @(posedge clk); #1;
         lat++;
         mw_any = mw_any | mw_s[d];
      end
      check({tag, "_lat"}, 64'(lat), 64'((d == 0) ? WS_A + 1 : WS_B + 1));
      rd = rdata_s[d]; e = err_s[d]; mw = mw_s[d]; da = adr_s[d]; wdo = wdo_s[d];
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(ready_s[d]), 64'(0));
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_s[i] = 1'b0; req_s[i] = 1'b0; we_s[i] = 1'b0;
         addr_s[i] = '0; wdata_s[i] = '0; be_s[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 64'(ready_s[0]), 64'(0));
      check("rst_err", 64'(err_s[0]), 64'(0));
      check("rst_mw", 64'(mw_s[0]), 64'(0));
      check("rst_rdata", 64'(rdata_s[0]), 64'(0));
      check("rst_wdo", 64'(wdo_s[0]), 64'(0));
      check("rst_adr", 64'(adr_s[0]), 64'(0));
      check("rst_mmio", 64'(mmio_s[0]), 64'(0));
      check("rst_b_ready", 64'(ready_s[1]), 64'(0));
      rst_s[0] = 1'b1; rst_s[1] = 1'b1;

      // Full-word write then read back
      acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "t1_wr");
      check("t1_wr_err", 64'(e), 64'(0));
      check("t1_wr_mw", 64'(mw), 64'(1));
      check("t1_wr_adr", 64'(da), 64'h10);
      check("t1_wr_wdo", 64'(wdo), 64'hDEADBEEF);
      acc(0, 1'b0, 32'h10, 32'h0, 4'h0, "t1_rd");
      check("t1_rd_data", 64'(rd), 64'hDEADBEEF);
      check("t1_rd_err", 64'(e), 64'(0));
      check("t1_rd_mw", 64'(mw), 64'(0));

      // Byte-enabled merge
      acc(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, "t2_wr");
      check("t2_wr_mw", 64'(mw), 64'(1));
      acc(0, 1'b0, 32'h10, 32'h0, 4'h0, "t2_rd");
      check("t2_rd_data", 64'(rd), 64'hDE22BE44);

      // Misaligned and out-of-range accesses
      acc(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, "t3_w0");
      acc(0, 1'b0, 32'h13, 32'h0, 4'h0, "t3_mis");
      check("t3_mis_err", 64'(e), 64'(1));
      check("t3_mis_rdata", 64'(rd), 64'hDE22BE44);
      check("t3_mis_mw", 64'(mw_any), 64'(0));
`ifdef MEM_CTRL_MMIO_EN
      acc(0, 1'b1, 32'h104, 32'hCAFEF00D, 4'hF, "t3_oor");
`else
      acc(0, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, "t3_oor");
`endif
      check("t3_oor_err", 64'(e), 64'(1));
      check("t3_oor_mw", 64'(mw_any), 64'(0));
      acc(0, 1'b0, 32'h0, 32'h0, 4'h0, "t3_rd0");
      check("t3_rd0_data", 64'(rd), 64'h0BADF00D);
      check("t3_rd0_err", 64'(e), 64'(0));

      // Reset in the middle of a write's wait states
      acc(0, 1'b1, 32'h20, 32'h12345678, 4'hF, "t5_pre");
      acc(0, 1'b0, 32'h10, 32'h0, 4'h0, "t5_rd");
      @(negedge clk);
      req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h20; wdata_s[0] = 32'hFFFFFFFF; be_s[0] = 4'hF;
      @(posedge clk); #1;
      req_s[0] = 1'b0;
      rst_s[0] = 1'b0;
      @(posedge clk); #1;
      rst_s[0] = 1'b1;
      check("t5_ready", 64'(ready_s[0]), 64'(0));
      check("t5_err", 64'(err_s[0]), 64'(0));
      check("t5_mw", 64'(mw_s[0]), 64'(0));
      check("t5_rdata", 64'(rdata_s[0]), 64'(0));
      check("t5_wdo", 64'(wdo_s[0]), 64'(0));
      check("t5_adr", 64'(adr_s[0]), 64'(0));
      check("t5_mmio", 64'(mmio_s[0]), 64'(0));
      any_evt = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         any_evt = any_evt | ready_s[0] | mw_s[0];
      end
      check("t5_quiet", 64'(any_evt), 64'(0));
      acc(0, 1'b0, 32'h20, 32'h0, 4'h0, "t5_rd20");
      check("t5_rd20_data", 64'(rd), 64'h12345678);

`ifdef MEM_CTRL_MMIO_EN
      acc(0, 1'b1, 32'h100, 32'hA5, 4'hF, "t6_wr");
      check("t6_wr_err", 64'(e), 64'(0));
      check("t6_wr_mw", 64'(mw), 64'(1));
      check("t6_mmio", 64'(mmio_s[0]), 64'hA5);
      acc(0, 1'b0, 32'h100, 32'h0, 4'h0, "t6_rd");
      check("t6_rd_data", 64'(rd), 64'hA5);
      check("t6_rd_err", 64'(e), 64'(0));
`endif

      // Zero wait states: back-to-back reads with req held high
      for (int i = 0; i < 4; i++) begin
         acc(1, 1'b1, 32'(i * 4), 32'h5555_0000 + 32'(i), 4'hF, $sformatf("t4_pre%0d", i));
      end
      @(negedge clk);
      req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h0; be_s[1] = 4'h0;
      for (int i = 0; i < 4; i++) begin
         gap = 0;
         do begin
            @(posedge clk); #1;
            gap++;
         end while (!ready_s[1] && gap < 10);
         check($sformatf("t4_gap%0d", i), 64'(gap), 64'(2));
         check($sformatf("t4_rd%0d", i), 64'(rdata_s[1]), 64'(32'h5555_0000 + 32'(i)));
         addr_s[1] = 32'((i + 1) * 4);
         if (i == 3) req_s[1] = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
